// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate D-cache with word-wide refill/write-back FSM.
// Latency: hits serve in the request cycle; misses stall via DCacheMiss until the line is resident.
// Backpressure: each memory word waits for a one-cycle mem_gnt; mem_* outputs hold until granted.
module data_cache #(
  parameter int LINE_ADDR_LEN = 2,
  parameter int SET_ADDR_LEN  = 3,
  parameter int TAG_ADDR_LEN  = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        DCacheMiss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_gnt
);
  localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
  localparam int SET_SIZE  = 1 << SET_ADDR_LEN;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;
  state_t state, state_nxt;

  logic [31:0]             line_data  [SET_SIZE][LINE_SIZE];
  logic [TAG_ADDR_LEN-1:0] line_tag   [SET_SIZE];
  logic [SET_SIZE-1:0]     line_valid;
  logic [SET_SIZE-1:0]     line_dirty;

  logic [LINE_ADDR_LEN-1:0] req_off;
  logic [SET_ADDR_LEN-1:0]  req_set;
  logic [TAG_ADDR_LEN-1:0]  req_tag;

  logic [SET_ADDR_LEN-1:0]  miss_set;
  logic [TAG_ADDR_LEN-1:0]  miss_tag;
  logic [TAG_ADDR_LEN-1:0]  victim_tag;
  logic [LINE_ADDR_LEN-1:0] word_cnt;

  logic req, hit, store_hit, miss_start, word_last, refill_done;
  logic unused_addr_bits;

  assign req_off = addr[LINE_ADDR_LEN+1:2];
  assign req_set = addr[LINE_ADDR_LEN+2 +: SET_ADDR_LEN];
  assign req_tag = addr[31 -: TAG_ADDR_LEN];
  assign unused_addr_bits = ^addr[1:0];

  assign req         = rd_req | wr_req;
  assign hit         = (state == IDLE) && line_valid[req_set] && (line_tag[req_set] == req_tag);
  assign store_hit   = hit & wr_req;
  assign miss_start  = (state == IDLE) & req & ~hit;
  assign word_last   = &word_cnt;
  assign refill_done = (state == REFILL) & mem_gnt & word_last;

  assign DCacheMiss = req & ~hit;
  assign rd_data    = hit ? line_data[req_set][req_off] : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (miss_start)
                   state_nxt = (line_valid[req_set] && line_dirty[req_set]) ? WRITEBACK : REFILL;
      WRITEBACK: if (mem_gnt && word_last) state_nxt = REFILL;
      REFILL:    if (mem_gnt && word_last) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Memory-side outputs depend only on registered state, so they hold steady until mem_gnt.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {victim_tag, miss_set, word_cnt, 2'b00};
        mem_wdata = line_data[miss_set][word_cnt];
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {miss_tag, miss_set, word_cnt, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt   <= '0;
      line_valid <= '0;
      line_dirty <= '0;
      miss_set   <= '0;
      miss_tag   <= '0;
      victim_tag <= '0;
    end else begin
      if (miss_start) begin
        miss_set   <= req_set;
        miss_tag   <= req_tag;
        victim_tag <= line_tag[req_set];
        word_cnt   <= '0;
      end
      if (state != IDLE && mem_gnt) word_cnt <= word_cnt + 1'b1;
      if (store_hit) line_dirty[req_set] <= 1'b1;
      if (refill_done) begin
        line_valid[miss_set] <= 1'b1;
        line_dirty[miss_set] <= 1'b0;
      end
    end
  end

  // Data and tag arrays carry no reset; validity alone decides whether they are meaningful.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (store_hit) line_data[req_set][req_off] <= wr_data;
      if (state == REFILL && mem_gnt) line_data[miss_set][word_cnt] <= mem_rdata;
      if (refill_done) line_tag[miss_set] <= miss_tag;
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed scenarios plus random traffic against a per-transaction cache/memory model.
module tb_data_cache;
  logic        clk = 1'b0;
  logic        rst, rd_req, wr_req, DCacheMiss, mem_req, mem_we, mem_gnt;
  logic [31:0] addr, wr_data, rd_data, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  data_cache dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .DCacheMiss(DCacheMiss),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_gnt(mem_gnt)
  );

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct {
    bit          we;
    logic [31:0] a;
    logic [31:0] d;
  } xfer_t;

  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  bit          m_valid [8];
  bit          m_dirty [8];
  int unsigned m_tag   [8];
  logic [31:0] m_data  [8][4];
  xfer_t       exp_q   [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a >= 32'h40 && a <= 32'h4C) return 32'hA0 + ((a - 32'h40) >> 2);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // One whole cache transaction at a time: queue the expected memory traffic, update the line.
  task automatic model_access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                              output bit hit, output int nwords, output logic [31:0] rdv);
    int unsigned w, off, set, tag;
    xfer_t x;
    w = a >> 2;
    off = w % 4;
    set = (w / 4) % 8;
    tag = w / 32;
    hit = m_valid[set] && (m_tag[set] == tag);
    nwords = 0;
    if (!hit) begin
      if (m_valid[set] && m_dirty[set]) begin
        for (int i = 0; i < 4; i++) begin
          x.we = 1'b1;
          x.a  = (m_tag[set] * 32 + set * 4 + i) * 4;
          x.d  = m_data[set][i];
          ref_mem[x.a] = x.d;
          exp_q.push_back(x);
          nwords++;
        end
      end
      for (int i = 0; i < 4; i++) begin
        x.we = 1'b0;
        x.a  = (tag * 32 + set * 4 + i) * 4;
        x.d  = '0;
        m_data[set][i] = ref_rd(x.a);
        exp_q.push_back(x);
        nwords++;
      end
      m_valid[set] = 1'b1;
      m_dirty[set] = 1'b0;
      m_tag[set]   = tag;
    end
    if (wr) begin
      m_data[set][off] = wd;
      m_dirty[set] = 1'b1;
      rdv = '0;
    end else begin
      rdv = m_data[set][off];
    end
  endtask

  // Entered and left at posedge+1; acts as CPU and as a memory with ws wait cycles per word.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input int ws, input int rst_after);
    bit          exp_hit, done;
    int          nwords, cyc, miss_cyc, waitc, grants;
    logic [31:0] exp_rd, hold_addr, hold_wd;
    logic        hold_we;
    xfer_t       x;
    model_access(wr, a, wd, exp_hit, nwords, exp_rd);
    rd_req = rd; wr_req = wr; addr = a; wr_data = wd;
    done = 0; cyc = 0; miss_cyc = 0; waitc = 0; grants = 0;
    hold_addr = '0; hold_wd = '0; hold_we = 1'b0;
    while (!done && cyc < 400) begin
      #3;
      if (cyc == 0) begin
        check_eq("miss_flag", DCacheMiss, !exp_hit);
        check_eq("mreq_first", mem_req, 1'b0);
        if (DCacheMiss) check_eq("rd_data_miss", rd_data, 32'h0);
      end
      if (!DCacheMiss) begin
        check_eq("mreq_hit", mem_req, 1'b0);
        if (!wr) check_eq("rd_data", rd_data, exp_rd);
        done = 1;
      end else begin
        miss_cyc++;
        if (mem_req) begin
          if (waitc == 0) begin
            hold_addr = mem_addr; hold_we = mem_we; hold_wd = mem_wdata;
          end else begin
            check_eq("hold_addr", mem_addr, hold_addr);
            check_eq("hold_we", mem_we, hold_we);
            check_eq("hold_wdata", mem_wdata, hold_wd);
          end
          if (waitc == ws) begin
            mem_gnt = 1'b1;
            mem_rdata = env_rd(mem_addr);
            if (exp_q.size() == 0) begin
              check_eq("xfer_extra", mem_addr, 32'hFFFF_FFFF);
            end else begin
              x = exp_q.pop_front();
              check_eq("xfer_we", mem_we, x.we);
              check_eq("xfer_addr", mem_addr, x.a);
              if (x.we) check_eq("wb_data", mem_wdata, x.d);
            end
            if (mem_we) env_mem[mem_addr] = mem_wdata;
            grants++;
            waitc = 0;
          end else begin
            waitc++;
          end
        end
      end
      @(posedge clk);
      #1;
      mem_gnt = 1'b0;
      cyc++;
      if (!done && rst_after > 0 && grants == rst_after) begin
        rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        #3;
        check_eq("mreq_after_rst", mem_req, 1'b0);
        check_eq("mwe_after_rst", mem_we, 1'b0);
        check_eq("miss_after_rst", DCacheMiss, 1'b0);
        model_reset();
        exp_q.delete();
        @(posedge clk);
        #1;
        return;
      end
    end
    if (!done) check_eq("timeout", cyc, 32'hFFFF_FFFF);
    check_eq("miss_cycles", miss_cyc, exp_hit ? 0 : 1 + nwords * (ws + 1));
    check_eq("xfers_left", exp_q.size(), 0);
    exp_q.delete();
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  initial begin
    int op, t, s, o;
    bit r, w;
    logic [31:0] a;
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wr_data = '0;
    mem_gnt = 1'b0; mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #3;
    check_eq("rst_miss", DCacheMiss, 1'b0);
    check_eq("rst_mreq", mem_req, 1'b0);
    check_eq("rst_mwe", mem_we, 1'b0);
    check_eq("rst_maddr", mem_addr, 32'h0);
    check_eq("rst_mwdata", mem_wdata, 32'h0);
    check_eq("rst_rdata", rd_data, 32'h0);
    @(posedge clk);
    #1;

    access(1, 0, 32'h40, 32'h0, 0, 0);
    access(0, 1, 32'h44, 32'h1234, 0, 0);
    access(1, 0, 32'h44, 32'h0, 0, 0);
    access(1, 0, 32'h240, 32'h0, 0, 0);
    access(1, 0, 32'h40, 32'h0, 3, 0);
    access(1, 0, 32'h240, 32'h0, 0, 2);
    access(1, 0, 32'h40, 32'h0, 0, 0);
    access(0, 1, 32'h80, 32'hBEEF, 0, 0);
    access(1, 0, 32'h280, 32'h0, 1, 0);

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        mem_gnt = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #3;
        check_eq("idle_mreq", mem_req, 1'b0);
        check_eq("idle_miss", DCacheMiss, 1'b0);
        @(posedge clk);
        #1 mem_gnt = 1'b0;
      end
      op = $urandom_range(0, 15);
      if (op == 0)     begin r = 1'b1; w = 1'b1; end
      else if (op < 7) begin r = 1'b0; w = 1'b1; end
      else             begin r = 1'b1; w = 1'b0; end
      t = $urandom_range(0, 3);
      s = $urandom_range(0, 7);
      o = $urandom_range(0, 3);
      a = ((t * 32 + s * 4 + o) * 4) | $urandom_range(0, 3);
      access(r, w, a, $urandom, $urandom_range(0, 2), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
